// File: rtl/modulo_entrada.sv
// Input conditioning for the processor core: synchronizes and debounces the
// raw enter button, captures the switch word on each accepted press and
// holds it with a valid flag until the core acknowledges it.
//
// state          | meaning
// SOLTO          | button released and stable, waiting for a press
// CONFIRMA_PRESS | s2 went high, counting stable high samples
// PRESSIONADO    | press accepted (or held at reset), waiting for release
// CONFIRMA_SOLTA | s2 went low, counting stable low samples
module modulo_entrada #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DATA_W          = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enter,
  input  logic [DATA_W-1:0] dadosIN,
  input  logic              ack,
  output logic [31:0]       dado,
  output logic              valido,
  output logic              pulso_enter,
  output logic              sobrescrita,
  output logic [1:0]        estado
);

  typedef enum logic [1:0] {
    SOLTO          = 2'd0,
    CONFIRMA_PRESS = 2'd1,
    PRESSIONADO    = 2'd2,
    CONFIRMA_SOLTA = 2'd3
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic              enter_s1, enter_s2;
  logic [DATA_W-1:0] dados_s1, dados_s2;
  state_t            state, state_n;
  logic [7:0]        cnt, cnt_n;
  logic              press_event;

  // Two-flop synchronizers for the button and every switch bit
  always_ff @(posedge clk) begin
    if (reset) begin
      enter_s1 <= 1'b0;
      enter_s2 <= 1'b0;
      dados_s1 <= '0;
      dados_s2 <= '0;
    end else begin
      enter_s1 <= enter;
      enter_s2 <= enter_s1;
      dados_s1 <= dadosIN;
      dados_s2 <= dados_s1;
    end
  end

  // Debounce state register; reset lands in PRESSIONADO so a button held
  // through reset must first be seen released before it can count
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= PRESSIONADO;
      cnt   <= 8'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state logic and press-event detection
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    press_event = 1'b0;
    unique case (state)
      SOLTO: begin
        if (enter_s2) begin
          state_n = CONFIRMA_PRESS;
          cnt_n   = 8'd1;
        end
      end
      CONFIRMA_PRESS: begin
        if (!enter_s2) begin
          state_n = SOLTO;
        end else if (cnt == CNT_LAST) begin
          state_n     = PRESSIONADO;
          press_event = 1'b1;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      PRESSIONADO: begin
        if (!enter_s2) begin
          state_n = CONFIRMA_SOLTA;
          cnt_n   = 8'd1;
        end
      end
      CONFIRMA_SOLTA: begin
        if (enter_s2) begin
          state_n = PRESSIONADO;
        end else if (cnt == CNT_LAST) begin
          state_n = SOLTO;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      default: state_n = PRESSIONADO;
    endcase
  end

  // Capture register and valid/ack handshake; a simultaneous ack means the
  // old word was consumed, so it is not reported as overwritten
  always_ff @(posedge clk) begin
    if (reset) begin
      dado        <= 32'd0;
      valido      <= 1'b0;
      pulso_enter <= 1'b0;
      sobrescrita <= 1'b0;
    end else begin
      pulso_enter <= press_event;
      if (press_event) begin
        dado   <= 32'(dados_s2);
        valido <= 1'b1;
        if (valido && !ack) begin
          sobrescrita <= 1'b1;
        end
      end else if (ack) begin
        valido <= 1'b0;
      end
    end
  end

  assign estado = state;

endmodule

// File: tb/tb_modulo_entrada.sv
// Bench for modulo_entrada: directed scenarios plus random button/ack/reset
// traffic, each cycle compared against a run-length debounce model.
module tb_modulo_entrada;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enter = 1'b0;
  logic [8:0]  dadosIN = 9'd0;
  logic        ack = 1'b0;
  logic [31:0] dado;
  logic        valido;
  logic        pulso_enter;
  logic        sobrescrita;
  logic [1:0]  estado;

  int compared   = 0;
  int mismatched = 0;
  int npulse     = 0;

  // reference model: raw inputs delayed two edges, debounced level flips
  // after D consecutive samples disagreeing with it
  logic        m_s1_e, m_s2_e;
  logic [8:0]  m_s1_d, m_s2_d;
  logic        m_level;
  int          m_run;
  logic [31:0] m_dado;
  logic        m_valid, m_pulse, m_sobre;

  modulo_entrada #(.DEBOUNCE_CYCLES(D), .DATA_W(9)) dut (
    .clk(clk), .reset(reset), .enter(enter), .dadosIN(dadosIN), .ack(ack),
    .dado(dado), .valido(valido), .pulso_enter(pulso_enter),
    .sobrescrita(sobrescrita), .estado(estado)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] model_estado();
    // released-stable 0, confirming press 1, pressed-stable 2, confirming release 3
    if (!m_level) return (m_run == 0) ? 2'd0 : 2'd1;
    else          return (m_run == 0) ? 2'd2 : 2'd3;
  endfunction

  task automatic model_step(input logic e, input logic [8:0] d, input logic a, input logic r);
    logic ev;
    if (r) begin
      m_s1_e = 0; m_s2_e = 0; m_s1_d = '0; m_s2_d = '0;
      m_level = 1'b1; m_run = 0;
      m_dado = '0; m_valid = 0; m_pulse = 0; m_sobre = 0;
    end else begin
      ev = 1'b0;
      if (m_s2_e != m_level) begin
        m_run++;
        if (m_run == D) begin
          m_level = !m_level;
          m_run   = 0;
          ev      = m_level;
        end
      end else begin
        m_run = 0;
      end
      m_pulse = ev;
      if (ev) begin
        if (m_valid && !a) m_sobre = 1'b1;
        m_dado  = {23'd0, m_s2_d};
        m_valid = 1'b1;
      end else if (a) begin
        m_valid = 1'b0;
      end
      m_s2_e = m_s1_e; m_s1_e = e;
      m_s2_d = m_s1_d; m_s1_d = d;
    end
  endtask

  task automatic tick(input logic e, input logic [8:0] d, input logic a, input logic r);
    @(negedge clk);
    enter = e; dadosIN = d; ack = a; reset = r;
    @(posedge clk);
    model_step(e, d, a, r);
    #1;
    chk("dado", dado, m_dado);
    chk("valido", {31'd0, valido}, {31'd0, m_valid});
    chk("pulso_enter", {31'd0, pulso_enter}, {31'd0, m_pulse});
    chk("sobrescrita", {31'd0, sobrescrita}, {31'd0, m_sobre});
    chk("estado", {30'd0, estado}, {30'd0, model_estado()});
    if (pulso_enter === 1'b1) npulse++;
  endtask

  initial begin
    int p0;
    logic lvl;
    int len;
    logic [6:0] bounce;

    // reset state
    tick(1'b0, 9'd0, 1'b0, 1'b1);
    chk("reset_estado", {30'd0, estado}, 32'd2);
    chk("reset_valido", {31'd0, valido}, 32'd0);

    // idle release reaches SOLTO
    for (int i = 0; i < 8; i++) tick(1'b0, 9'd0, 1'b0, 1'b0);
    chk("idle_estado", {30'd0, estado}, 32'd0);

    // single press: pulse visible exactly after the sixth edge (E5)
    p0 = npulse;
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 9'h1A5, 1'b0, 1'b0);
      chk("press_pulse_timing", {31'd0, pulso_enter}, (i == 5) ? 32'd1 : 32'd0);
    end
    chk("press_npulse", npulse - p0, 32'd1);
    chk("press_dado", dado, 32'h000001A5);
    chk("press_valido", {31'd0, valido}, 32'd1);
    tick(1'b0, 9'h000, 1'b1, 1'b0);
    chk("ack_valido", {31'd0, valido}, 32'd0);
    chk("ack_dado", dado, 32'h000001A5);
    for (int i = 0; i < 8; i++) tick(1'b0, 9'h000, 1'b0, 1'b0);

    // bounce shorter than the debounce window
    p0 = npulse;
    bounce = 7'b0111011;
    for (int i = 0; i < 7; i++) tick(bounce[6-i], 9'h1FF, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) tick(1'b0, 9'h1FF, 1'b0, 1'b0);
    chk("bounce_npulse", npulse - p0, 32'd0);
    chk("bounce_valido", {31'd0, valido}, 32'd0);
    chk("bounce_estado", {30'd0, estado}, 32'd0);

    // overwrite without ack
    for (int i = 0; i < 10; i++) tick(1'b1, 9'h003, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) tick(1'b0, 9'h003, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) tick(1'b1, 9'h0FF, 1'b0, 1'b0);
    chk("ovw_dado", dado, 32'h000000FF);
    chk("ovw_valido", {31'd0, valido}, 32'd1);
    chk("ovw_sobrescrita", {31'd0, sobrescrita}, 32'd1);
    for (int i = 0; i < 10; i++) tick(1'b0, 9'h0FF, 1'b0, 1'b0);

    // ack coinciding with the next press event
    tick(1'b0, 9'h000, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) tick(1'b0, 9'h000, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) tick(1'b1, 9'h055, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) tick(1'b0, 9'h055, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) tick(1'b1, 9'h0AA, (i == 5), 1'b0);
    chk("coinc_valido", {31'd0, valido}, 32'd1);
    chk("coinc_dado", dado, 32'h000000AA);
    chk("coinc_sobrescrita", {31'd0, sobrescrita}, 32'd0);

    // button held through reset never counts
    p0 = npulse;
    tick(1'b1, 9'h011, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) tick(1'b1, 9'h011, 1'b0, 1'b0);
    chk("held_npulse", npulse - p0, 32'd0);
    chk("held_valido", {31'd0, valido}, 32'd0);
    for (int i = 0; i < 6; i++) tick(1'b0, 9'h011, 1'b0, 1'b0);
    chk("held_release_estado", {30'd0, estado}, 32'd0);
    for (int i = 0; i < 10; i++) tick(1'b1, 9'h022, 1'b0, 1'b0);
    chk("held_repress_npulse", npulse - p0, 32'd1);
    chk("held_repress_dado", dado, 32'h00000022);

    // random traffic against the model
    lvl = 1'b1;
    for (int k = 0; k < 120; k++) begin
      lvl = !lvl;
      len = $urandom_range(1, 9);
      for (int j = 0; j < len; j++)
        tick(lvl, 9'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 79) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
